// File: rtl/stream_acc_ctrl.sv
// stream_acc_ctrl
//
// Sequencing controller for the stream accumulator datapath. Counts accepted
// samples into packets of AMOUNT_OF_DATA and packets into frames of
// AMOUNT_OF_PACKET. Drives the adder/sum-register strobes and emits sum-valid
// and frame-done pulses delayed to line up with the datapath pipeline.
//
// Optional feature macro: STREAM_ACC_CTRL_ERR_EN
//   defined     -> err_o is a sticky flag set by valid_in_i during DRAIN or by
//                  start_i while busy; cleared only by rst_i.
//   not defined -> err_o is tied low and no detection logic exists.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   start_i        begin a frame (only looked at in IDLE)
//   valid_in_i     upstream sample valid
//   busy_o         high in RUN and DRAIN
//   acc_en_o       registered: datapath adds or loads this cycle
//   acc_load_o     registered: first sample of a packet, load instead of add
//   data_idx_o     index of the next expected sample within its packet
//   packet_idx_o   index of the current packet within the frame
//   sum_valid_o    one-cycle pulse, packet sum is final
//   frame_done_o   one-cycle pulse, coincident with the last packet's sum_valid_o
//   err_o          sticky drop flag (see macro above)

module stream_acc_ctrl #(
  parameter int unsigned AMOUNT_OF_DATA   = 16,
  parameter int unsigned AMOUNT_OF_PACKET = 8,
  parameter int unsigned PIPE_LAT         = 3,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_in_i,
  output logic             busy_o,
  output logic             acc_en_o,
  output logic             acc_load_o,
  output logic [CNT_W-1:0] data_idx_o,
  output logic [CNT_W-1:0] packet_idx_o,
  output logic             sum_valid_o,
  output logic             frame_done_o,
  output logic             err_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Terminal counts; AMOUNT_OF_* may equal 2^CNT_W, so the last index is all ones.
  localparam logic [CNT_W-1:0] DataLast = CNT_W'(AMOUNT_OF_DATA - 1);
  localparam logic [CNT_W-1:0] PktLast  = CNT_W'(AMOUNT_OF_PACKET - 1);

  localparam int unsigned      DrainW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(PIPE_LAT - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    data_idx_q, data_idx_d;
  logic [CNT_W-1:0]    packet_idx_q, packet_idx_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                acc_en_q, acc_en_d;
  logic                acc_load_q, acc_load_d;
  logic [PIPE_LAT-1:0] last_dly_q, last_dly_d;
  logic [PIPE_LAT-1:0] frame_dly_q, frame_dly_d;

  logic accept;
  logic last_in;
  logic frame_in;
  logic busy;

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Sequencing FSM and index counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    data_idx_d   = data_idx_q;
    packet_idx_d = packet_idx_q;
    drain_cnt_d  = drain_cnt_q;
    accept       = 1'b0;
    last_in      = 1'b0;
    frame_in     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d      = StRun;
          data_idx_d   = '0;
          packet_idx_d = '0;
        end
      end

      StRun: begin
        if (valid_in_i) begin
          accept = 1'b1;
          if (data_idx_q == DataLast) begin
            data_idx_d = '0;
            last_in    = 1'b1;
            if (packet_idx_q == PktLast) begin
              packet_idx_d = '0;
              frame_in     = 1'b1;
              state_d      = StDrain;
              drain_cnt_d  = '0;
            end else begin
              packet_idx_d = packet_idx_q + 1'b1;
            end
          end else begin
            data_idx_d = data_idx_q + 1'b1;
          end
        end
      end

      // Holds off a new frame until the final flags have left the delay line.
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath strobes (registered, one cycle after acceptance)
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_en_d   = accept;
    acc_load_d = accept && (data_idx_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Flag delay line: stage 0 is loaded at acceptance + 1, so the last stage
  // presents the flag exactly PIPE_LAT cycles after the sample was accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    last_dly_d     = last_dly_q;
    frame_dly_d    = frame_dly_q;
    last_dly_d[0]  = last_in;
    frame_dly_d[0] = frame_in;
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      last_dly_d[i]  = last_dly_q[i-1];
      frame_dly_d[i] = frame_dly_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      data_idx_q   <= '0;
      packet_idx_q <= '0;
      drain_cnt_q  <= '0;
      acc_en_q     <= 1'b0;
      acc_load_q   <= 1'b0;
      last_dly_q   <= '0;
      frame_dly_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_idx_q   <= data_idx_d;
      packet_idx_q <= packet_idx_d;
      drain_cnt_q  <= drain_cnt_d;
      acc_en_q     <= acc_en_d;
      acc_load_q   <= acc_load_d;
      last_dly_q   <= last_dly_d;
      frame_dly_q  <= frame_dly_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional sticky error flag
  // ---------------------------------------------------------------------------
`ifdef STREAM_ACC_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == StDrain) && valid_in_i) begin
      err_d = 1'b1;
    end
    if (busy && start_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o       = busy;
  assign acc_en_o     = acc_en_q;
  assign acc_load_o   = acc_load_q;
  assign data_idx_o   = data_idx_q;
  assign packet_idx_o = packet_idx_q;
  assign sum_valid_o  = last_dly_q[PIPE_LAT-1];
  assign frame_done_o = frame_dly_q[PIPE_LAT-1];

endmodule

// File: tb/tb_stream_acc_ctrl.sv
// Bench for stream_acc_ctrl. Two instances share one stimulus stream:
//   dut0: AMOUNT_OF_DATA=4, AMOUNT_OF_PACKET=2, PIPE_LAT=3
//   dut1: AMOUNT_OF_DATA=1, AMOUNT_OF_PACKET=3, PIPE_LAT=2
// A cycle-indexed event model predicts every output on every cycle, and a set
// of hand-computed literal expectations pins the model against the timing
// rules. Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.

module tb_stream_acc_ctrl;

`ifdef STREAM_ACC_CTRL_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam int LogLen = 512;

  logic clk;
  logic rst;
  logic start;
  logic valid_in;

  logic       busy_w   [2];
  logic       en_w     [2];
  logic       ld_w     [2];
  logic [7:0] didx_w   [2];
  logic [7:0] pidx_w   [2];
  logic       sv_w     [2];
  logic       fd_w     [2];
  logic       err_w    [2];

  stream_acc_ctrl #(
    .AMOUNT_OF_DATA  (4),
    .AMOUNT_OF_PACKET(2),
    .PIPE_LAT        (3),
    .CNT_W           (8)
  ) u_dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .valid_in_i  (valid_in),
    .busy_o      (busy_w[0]),
    .acc_en_o    (en_w[0]),
    .acc_load_o  (ld_w[0]),
    .data_idx_o  (didx_w[0]),
    .packet_idx_o(pidx_w[0]),
    .sum_valid_o (sv_w[0]),
    .frame_done_o(fd_w[0]),
    .err_o       (err_w[0])
  );

  stream_acc_ctrl #(
    .AMOUNT_OF_DATA  (1),
    .AMOUNT_OF_PACKET(3),
    .PIPE_LAT        (2),
    .CNT_W           (8)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .valid_in_i  (valid_in),
    .busy_o      (busy_w[1]),
    .acc_en_o    (en_w[1]),
    .acc_load_o  (ld_w[1]),
    .data_idx_o  (didx_w[1]),
    .packet_idx_o(pidx_w[1]),
    .sum_valid_o (sv_w[1]),
    .frame_done_o(fd_w[1]),
    .err_o       (err_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  function automatic int cfg_ad(input int k);
    return (k == 0) ? 4 : 1;
  endfunction
  function automatic int cfg_ap(input int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic int cfg_pl(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: mode 0=idle 1=run 2=drain; future pulses stored by absolute cycle.
  // ---------------------------------------------------------------------------
  int m_mode [2];
  int m_di   [2];
  int m_pi   [2];
  int m_dend [2];
  bit m_en   [2];
  bit m_ld   [2];
  bit m_err  [2];
  bit exp_sv [2][LogLen];
  bit exp_fd [2][LogLen];

  bit lg_busy [2][LogLen];
  bit lg_en   [2][LogLen];
  bit lg_ld   [2][LogLen];
  bit lg_sv   [2][LogLen];
  bit lg_fd   [2][LogLen];

  // Applies the inputs of cycle e-1 to produce the expected outputs of cycle e.
  task automatic model_step(input int e);
    int t;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0;
        m_di[k]   = 0;
        m_pi[k]   = 0;
        m_en[k]   = 1'b0;
        m_ld[k]   = 1'b0;
        m_err[k]  = 1'b0;
        for (int j = e; j < LogLen; j++) begin
          exp_sv[k][j] = 1'b0;
          exp_fd[k][j] = 1'b0;
        end
      end else begin
        if (ErrEn && ((m_mode[k] == 2 && valid_in) || (m_mode[k] != 0 && start))) begin
          m_err[k] = 1'b1;
        end
        m_en[k] = 1'b0;
        m_ld[k] = 1'b0;
        t = e - 1;
        if (m_mode[k] == 0) begin
          if (start) begin
            m_mode[k] = 1;
            m_di[k]   = 0;
            m_pi[k]   = 0;
          end
        end else if (m_mode[k] == 1) begin
          if (valid_in) begin
            m_en[k] = 1'b1;
            m_ld[k] = (m_di[k] == 0);
            if (m_di[k] == cfg_ad(k) - 1) begin
              m_di[k] = 0;
              exp_sv[k][t + cfg_pl(k)] = 1'b1;
              if (m_pi[k] == cfg_ap(k) - 1) begin
                m_pi[k] = 0;
                exp_fd[k][t + cfg_pl(k)] = 1'b1;
                m_mode[k] = 2;
                m_dend[k] = t + cfg_pl(k);
              end else begin
                m_pi[k]++;
              end
            end else begin
              m_di[k]++;
            end
          end
        end else begin
          if (e > m_dend[k]) m_mode[k] = 0;
        end
      end
    end
  endtask

  // Compare process: every cycle, every output of both instances.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(cyc);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("busy",       k, int'(busy_w[k]), int'(m_mode[k] != 0));
        chk("acc_en",     k, int'(en_w[k]),   int'(m_en[k]));
        chk("acc_load",   k, int'(ld_w[k]),   int'(m_ld[k]));
        chk("data_idx",   k, int'(didx_w[k]), m_di[k]);
        chk("packet_idx", k, int'(pidx_w[k]), m_pi[k]);
        chk("sum_valid",  k, int'(sv_w[k]),   int'(exp_sv[k][cyc]));
        chk("frame_done", k, int'(fd_w[k]),   int'(exp_fd[k][cyc]));
        chk("err",        k, int'(err_w[k]),  int'(m_err[k]));
        lg_busy[k][cyc] = busy_w[k];
        lg_en[k][cyc]   = en_w[k];
        lg_ld[k][cyc]   = ld_w[k];
        lg_sv[k][cyc]   = sv_w[k];
        lg_fd[k][cyc]   = fd_w[k];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations (s = cycle start is high)
  // ---------------------------------------------------------------------------
  initial begin
    int s;
    rst      = 1'b1;
    start    = 1'b1;
    valid_in = 1'b1;

    // Reset defaults with start/valid asserted.
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy",     k, int'(busy_w[k]), 0);
      chk("rst_acc_en",   k, int'(en_w[k]),   0);
      chk("rst_data_idx", k, int'(didx_w[k]), 0);
      chk("rst_sum_val",  k, int'(sv_w[k]),   0);
    end
    rst      = 1'b0;
    start    = 1'b0;
    valid_in = 1'b0;
    step(1);

    // Continuous frame.
    s = cyc;
    start = 1'b1;
    step(1);
    start    = 1'b0;
    valid_in = 1'b1;
    step(8);
    valid_in = 1'b0;
    step(6);
    chk("cont_busy_s1",  0, int'(lg_busy[0][s+1]), 1);
    chk("cont_load_2",   0, int'(lg_ld[0][s+2]),   1);
    chk("cont_load_3",   0, int'(lg_ld[0][s+3]),   0);
    chk("cont_load_6",   0, int'(lg_ld[0][s+6]),   1);
    chk("cont_en_2",     0, int'(lg_en[0][s+2]),   1);
    chk("cont_en_9",     0, int'(lg_en[0][s+9]),   1);
    chk("cont_en_10",    0, int'(lg_en[0][s+10]),  0);
    chk("cont_sv_7",     0, int'(lg_sv[0][s+7]),   1);
    chk("cont_sv_8",     0, int'(lg_sv[0][s+8]),   0);
    chk("cont_sv_11",    0, int'(lg_sv[0][s+11]),  1);
    chk("cont_fd_7",     0, int'(lg_fd[0][s+7]),   0);
    chk("cont_fd_11",    0, int'(lg_fd[0][s+11]),  1);
    chk("cont_busy_11",  0, int'(lg_busy[0][s+11]), 1);
    chk("cont_busy_12",  0, int'(lg_busy[0][s+12]), 0);
    // Single-sample packets on dut1: samples at s+1..s+3, PIPE_LAT=2.
    for (int i = 2; i <= 4; i++) chk("one_load", 1, int'(lg_ld[1][s+i]), 1);
    for (int i = 3; i <= 5; i++) chk("one_sv",   1, int'(lg_sv[1][s+i]), 1);
    chk("one_sv_6",  1, int'(lg_sv[1][s+6]), 0);
    chk("one_fd_4",  1, int'(lg_fd[1][s+4]), 0);
    chk("one_fd_5",  1, int'(lg_fd[1][s+5]), 1);
    chk("one_busy6", 1, int'(lg_busy[1][s+6]), 0);

    // Gapped input: samples at s+1, s+3, ..., s+15.
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid_in = ((i % 2) == 0);
      step(1);
    end
    valid_in = 1'b0;
    step(4);
    chk("gap_load_2",  0, int'(lg_ld[0][s+2]),   1);
    chk("gap_load_10", 0, int'(lg_ld[0][s+10]),  1);
    chk("gap_sv_9",    0, int'(lg_sv[0][s+9]),   0);
    chk("gap_sv_10",   0, int'(lg_sv[0][s+10]),  1);
    chk("gap_fd_18",   0, int'(lg_fd[0][s+18]),  1);
    chk("gap_busy_18", 0, int'(lg_busy[0][s+18]), 1);
    chk("gap_busy_19", 0, int'(lg_busy[0][s+19]), 0);

    // Drops in DRAIN and start while busy.
    s = cyc;
    start = 1'b1;
    step(1);
    start    = 1'b0;
    valid_in = 1'b1;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    valid_in = 1'b0;
    step(2);
    chk("drop_en_9",   0, int'(lg_en[0][s+9]),   1);
    chk("drop_en_10",  0, int'(lg_en[0][s+10]),  0);
    chk("drop_en_13",  0, int'(lg_en[0][s+13]),  0);
    chk("drop_fd_11",  0, int'(lg_fd[0][s+11]),  1);
    chk("drop_busy12", 0, int'(lg_busy[0][s+12]), 0);
    chk("drop_busy13", 0, int'(lg_busy[0][s+13]), 0);
    chk("drop_err",    0, int'(err_w[0]), int'(ErrEn));

    // Reset mid-frame at the 3rd sample of packet 1.
    s = cyc;
    start = 1'b1;
    step(1);
    start    = 1'b0;
    valid_in = 1'b1;
    step(6);
    rst = 1'b1;
    step(1);
    rst      = 1'b0;
    valid_in = 1'b0;
    chk("mid_rst_err", 0, int'(err_w[0]), 0);
    step(8);
    chk("mid_sv_7", 0, int'(lg_sv[0][s+7]), 1);
    for (int i = 8; i <= 16; i++) begin
      chk("mid_no_sv", 0, int'(lg_sv[0][s+i]), 0);
      chk("mid_no_fd", 0, int'(lg_fd[0][s+i]), 0);
    end

    // Fresh full frame after the mid-frame reset.
    s = cyc;
    start = 1'b1;
    step(1);
    start    = 1'b0;
    valid_in = 1'b1;
    step(8);
    valid_in = 1'b0;
    step(5);
    chk("fresh_load_2", 0, int'(lg_ld[0][s+2]),   1);
    chk("fresh_sv_7",   0, int'(lg_sv[0][s+7]),   1);
    chk("fresh_fd_11",  0, int'(lg_fd[0][s+11]),  1);
    chk("fresh_busy12", 0, int'(lg_busy[0][s+12]), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
